// File: rtl/step_pkg.sv
// Shared motor-phase definitions: half-step coil patterns, pattern-to-index decode and
// decoder FSM encoding.
package step_pkg;

    localparam logic [3:0] PAT_0    = 4'b0001;
    localparam logic [3:0] PAT_1    = 4'b0011;
    localparam logic [3:0] PAT_2    = 4'b0010;
    localparam logic [3:0] PAT_3    = 4'b0110;
    localparam logic [3:0] PAT_4    = 4'b0100;
    localparam logic [3:0] PAT_5    = 4'b1100;
    localparam logic [3:0] PAT_6    = 4'b1000;
    localparam logic [3:0] PAT_7    = 4'b1001;
    localparam logic [3:0] IDLE_PAT = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } pat_idx_t;

    // Half-step table position of a coil pattern; vld=0 for anything outside the table
    function automatic pat_idx_t pat_to_idx(input logic [3:0] pat);
        pat_idx_t r;
        r.vld = 1'b1;
        r.idx = 3'd0;
        case (pat)
            PAT_0:   r.idx = 3'd0;
            PAT_1:   r.idx = 3'd1;
            PAT_2:   r.idx = 3'd2;
            PAT_3:   r.idx = 3'd3;
            PAT_4:   r.idx = 3'd4;
            PAT_5:   r.idx = 3'd5;
            PAT_6:   r.idx = 3'd6;
            PAT_7:   r.idx = 3'd7;
            default: r.vld = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/phase_filter.sv
// Two-flop synchronizer followed by a run-length stability filter; q moves only after
// FILT_LEN identical synchronized samples, with a one-cycle q_chg pulse on each move.
module phase_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       q_chg
);

    localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       prev;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_nxt;
    logic             accept_c;

    always_comb begin
        run_nxt  = CNT_W'(1);
        accept_c = 1'b0;
        if (sync2 == prev) begin
            run_nxt = (run >= CNT_W'(FILT_LEN)) ? run : run + CNT_W'(1);
        end
        accept_c = (run_nxt >= CNT_W'(FILT_LEN)) && (sync2 != q);
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
            prev  <= 4'b0000;
            run   <= '0;
            q     <= 4'b0000;
            q_chg <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
            prev  <= sync2;
            run   <= run_nxt;
            q_chg <= accept_c;
            if (accept_c) begin
                q <= sync2;
            end
        end
    end

endmodule

// File: rtl/step_phase_decoder.sv
// Turns filtered half-step coil patterns into step events, direction, signed position,
// step period and skip/illegal/stall fault indications.
module step_phase_decoder
    import step_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned POS_W    = 32,
    parameter int unsigned PER_W    = 32,
    parameter logic [31:0] TIMEOUT  = 32'd400_000
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic [3:0]       phase_in,
    input  logic             clr_pos,
    output logic [POS_W-1:0] position,
    output logic             direct_o,
    output logic             step_pulse,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             stalled,
    output logic             err_skip,
    output logic             err_illegal,
    output logic [15:0]      err_cnt
);

    localparam int unsigned ERR_W = 16;

    logic [3:0]       filt_q;
    logic             filt_chg;

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic             hist_vld, hist_nxt;
    logic [PER_W-1:0] cnt, cnt_nxt;
    logic [POS_W-1:0] pos_base, pos_nxt;
    logic             dir_nxt, step_nxt, pvld_nxt, stall_nxt, skip_nxt, ill_nxt;
    logic [PER_W-1:0] period_nxt;
    logic [ERR_W-1:0] err_base, err_nxt;
    pat_idx_t         pi;
    logic [2:0]       delta;

    phase_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .d       (phase_in),
        .q       (filt_q),
        .q_chg   (filt_chg)
    );

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        hist_nxt   = hist_vld;
        cnt_nxt    = '0;
        dir_nxt    = direct_o;
        period_nxt = period;
        step_nxt   = 1'b0;
        pvld_nxt   = 1'b0;
        stall_nxt  = stalled;
        skip_nxt   = 1'b0;
        ill_nxt    = 1'b0;
        pi         = pat_to_idx(filt_q);
        delta      = pi.idx - idx;
        pos_base   = clr_pos ? '0 : position;
        pos_nxt    = pos_base;

        if (state == ST_TRACK) begin
            cnt_nxt = (cnt == '1) ? cnt : cnt + PER_W'(1);
        end

        if (filt_chg) begin
            if (filt_q == IDLE_PAT) begin
                state_nxt = ST_IDLE;
                hist_nxt  = 1'b0;
                stall_nxt = 1'b0;
                cnt_nxt   = '0;
            end else if (!pi.vld) begin
                ill_nxt = 1'b1;
                if (state == ST_TRACK) begin
                    state_nxt = ST_FAULT;
                    hist_nxt  = 1'b0;
                    stall_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end else if (state != ST_TRACK) begin
                // Re-entry from IDLE/FAULT only anchors the index
                state_nxt = ST_TRACK;
                idx_nxt   = pi.idx;
                hist_nxt  = 1'b0;
                stall_nxt = 1'b0;
                cnt_nxt   = PER_W'(1);
            end else begin
                idx_nxt = pi.idx;
                if (delta == 3'd1 || delta == 3'd7) begin
                    step_nxt  = 1'b1;
                    dir_nxt   = (delta == 3'd1);
                    pos_nxt   = (delta == 3'd1) ? pos_base + POS_W'(1) : pos_base - POS_W'(1);
                    pvld_nxt  = hist_vld;
                    if (hist_vld) begin
                        period_nxt = cnt;
                    end
                    hist_nxt  = 1'b1;
                    stall_nxt = 1'b0;
                    cnt_nxt   = PER_W'(1);
                end else begin
                    skip_nxt = 1'b1;
                end
            end
        end

        // A step or leaving TRACK in the same cycle takes priority over the stall
        if (state == ST_TRACK && state_nxt == ST_TRACK && !step_nxt && cnt >= PER_W'(TIMEOUT)) begin
            stall_nxt = 1'b1;
            hist_nxt  = 1'b0;
        end

        err_base = clr_pos ? '0 : err_cnt;
        err_nxt  = err_base;
        if ((skip_nxt || ill_nxt) && err_base != '1) begin
            err_nxt = err_base + ERR_W'(1);
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= ST_IDLE;
            idx         <= 3'd0;
            hist_vld    <= 1'b0;
            cnt         <= '0;
            position    <= '0;
            direct_o    <= 1'b0;
            step_pulse  <= 1'b0;
            period      <= '0;
            period_vld  <= 1'b0;
            stalled     <= 1'b0;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            hist_vld    <= hist_nxt;
            cnt         <= cnt_nxt;
            position    <= pos_nxt;
            direct_o    <= dir_nxt;
            step_pulse  <= step_nxt;
            period      <= period_nxt;
            period_vld  <= pvld_nxt;
            stalled     <= stall_nxt;
            err_skip    <= skip_nxt;
            err_illegal <= ill_nxt;
            err_cnt     <= err_nxt;
        end
    end

endmodule
